// File: rtl/bf_out_uart.sv
// BF CPU output stage: buffers OUT bytes in a small FIFO and serialises them
// on an 8N1 UART TX line, LSB first. Bytes offered while the FIFO is full are dropped and flagged.
module bf_out_uart #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       out_valid,
  input  logic [7:0] out_data,
  input  logic       overflow_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int BW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_tx, r_busy, r_overflow;
  logic          w_full, w_empty, w_push, w_pop, w_baud_last, w_tx_nxt;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push      = out_valid & ~w_full;
  assign w_baud_last = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt = r_shreg[0];
        if (w_baud_last && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_last) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (out_valid && w_full) r_overflow <= 1'b1;
      else if (overflow_clr)   r_overflow <= 1'b0;
    end
  end

  // tx is the registered image of the current state, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_baud_last) r_baud <= '0;
      else                                  r_baud <= r_baud + BW'(1);
      if (r_state != S_DATA)  r_bit <= '0;
      else if (w_baud_last)   r_bit <= r_bit + 3'd1;
      if (w_pop)                                  r_shreg <= r_mem[r_rd_ptr];
      else if (r_state == S_DATA && w_baud_last)  r_shreg <= {1'b0, r_shreg[7:1]};
      r_tx   <= w_tx_nxt;
      r_busy <= (r_state != S_IDLE) | ~w_empty;
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bf_out_uart.sv
// Bench for bf_out_uart: directed vectors, expected bytes queued at issue time,
// a UART decoder process pops and compares every frame seen on tx.
module tb_bf_out_uart;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       out_valid = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       overflow_clr = 1'b0;
  logic       tx, busy, fifo_full, overflow;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  bf_out_uart #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_data(out_data),
    .overflow_clr(overflow_clr), .tx(tx), .busy(busy), .fifo_full(fifo_full),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, required finish before limit");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one byte for exactly one cycle; returns just after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    out_valid = 1'b1;
    out_data  = b;
    @(posedge clk); #1;
    out_valid = 1'b0;
    out_data  = 8'hxx;
  endtask

  // Expected tx k cycles after the write edge into an empty idle block.
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < 2)        return 1'b1;
    else if (k < 6)   return 1'b0;
    else if (k < 38)  return b[(k-6)/CPB];
    else              return 1'b1;
  endfunction

  // Called right after send(): checks tx and busy waveforms cycle by cycle.
  task automatic check_frame(input logic [7:0] b, input string name);
    int tx_bad_k = -1;
    int bs_bad_k = -1;
    if (busy !== 1'b0) bs_bad_k = 0;
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (tx !== exp_tx(k, b) && tx_bad_k < 0) tx_bad_k = k;
      if (busy !== (k < 42) && bs_bad_k < 0)   bs_bad_k = k;
    end
    check({name, "_tx_wave_first_bad_cycle"}, tx_bad_k, -1);
    check({name, "_busy_wave_first_bad_cycle"}, bs_bad_k, -1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) tick();
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_idle_within_budget"}, int'(busy === 1'b0), 1);
    repeat (4) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [7:0] b;
    logic       ab, st_ok, sp_ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ab = 1'b0; b = 8'h00; st_ok = 1'b0; sp_ok = 1'b0;
        for (int s = 0; s < 38 && !ab; s++) begin
          @(negedge clk);
          if (rst_n !== 1'b1)                         ab = 1'b1;
          else if (s == 1)                            st_ok = (tx === 1'b0);
          else if (s >= 5 && s <= 33 && (s-5)%4 == 0) b[(s-5)/4] = tx;
          else if (s == 37)                           sp_ok = (tx === 1'b1);
        end
        if (!ab) begin
          check("mon_start_bit", int'(st_ok), 1);
          check("mon_stop_bit", int'(sp_ok), 1);
          if (exp_q.size() == 0) check("mon_unexpected_byte", int'(b), -1);
          else                   check("mon_byte", int'(b), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int bad_k;
    out_data = 8'hxx;

    // 1: reset values and quiet idle line
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_k = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((tx !== 1'b1 || busy !== 1'b0) && bad_k < 0) bad_k = k;
    end
    check("idle_hold_first_bad_cycle", bad_k, -1);

    // 2: single byte, exact latency and frame length
    exp_q.push_back(8'h48);
    send(8'h48);
    check_frame(8'h48, "single_48");
    wait_idle("single_48");

    // 3: back-to-back frames with no idle gap
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    send(8'h41);
    send(8'h42);
    for (int k = 2; k <= 41; k++) tick();
    check("b2b_stop_before_2nd_start", int'(tx), 1);
    tick();
    check("b2b_2nd_start_at_n42", int'(tx), 0);
    wait_idle("b2b");

    // 4: overflow; 6: set beats clear on the same edge
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i));
    end
    check("ovf_full_after_5", int'(fifo_full), 1);
    check("ovf_clear_before_drop", int'(overflow), 0);
    send(8'h06);
    check("ovf_set_on_drop", int'(overflow), 1);
    check("ovf_still_full", int'(fifo_full), 1);
    @(negedge clk);
    out_valid = 1'b1; out_data = 8'h07; overflow_clr = 1'b1;
    @(posedge clk); #1;
    out_valid = 1'b0; out_data = 8'hxx; overflow_clr = 1'b0;
    check("ovf_set_wins_over_clr", int'(overflow), 1);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    wait_idle("ovf");
    check("ovf_not_full_after_drain", int'(fifo_full), 0);

    // 5: reset in the middle of a 0x00 frame
    send(8'h00);
    repeat (16) tick();
    check("midrst_line_low_before", int'(tx), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_high", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_fifo_full", int'(fifo_full), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad_k = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ((tx !== 1'b1 || busy !== 1'b0) && bad_k < 0) bad_k = k;
    end
    check("midrst_quiet_first_bad_cycle", bad_k, -1);
    exp_q.push_back(8'h5A);
    send(8'h5A);
    check_frame(8'h5A, "post_rst_5a");
    wait_idle("post_rst");

    repeat (10) tick();
    check("all_expected_bytes_seen", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
